// File: rtl/mic_pair_scheduler.sv
// ---------------------------------------------------------------------------
// mic_pair_scheduler
//
// Sequences a bank of NUM_PAIRS mic-pair cross-correlation subsystems, one at
// a time, round-robin within a frame. For each pair it issues a start pulse,
// waits for that pair's done pulse, and latches its signed lag result. When
// every pair has been serviced, it emits a one-cycle frame_valid pulse and
// bumps the frame counter. If sched_en is still high, the next frame starts
// with no idle cycle in between.
//
// Optional feature (compile-time macro MIC_SCHED_TIMEOUT_EN):
//   Defined   - per-pair watchdog. A pair that does not answer within
//               TIMEOUT_CYC cycles gets its timeout flag set and its lag
//               forced to 0, and the frame moves on.
//   Undefined - no watchdog. WAIT exits only on the selected pair's done,
//               and timeout_flags is tied to 0.
//
// Parameters
//   NUM_PAIRS    number of pairs sequenced (2..8)
//   LAG_W        width of each pair's signed lag
//   TIMEOUT_CYC  watchdog limit in clk_60MHz cycles (only with the macro)
//
// Ports
//   clk_60MHz      in   sole clock, rising edge
//   rst_n          in   asynchronous, active-low reset
//   sched_en       in   level, requests continuous frame scheduling
//   pair_done      in   [NUM_PAIRS]        per-pair one-cycle done pulse
//   pair_lag       in   [NUM_PAIRS*LAG_W]  per-pair lag, pair i at [i*LAG_W +: LAG_W]
//   pair_start     out  [NUM_PAIRS]        one-hot, one-cycle start pulse
//   lag_out        out  [NUM_PAIRS*LAG_W]  latched lags, same packing as pair_lag
//   timeout_flags  out  [NUM_PAIRS]        pair timed out in the current/last frame
//   frame_valid    out  one-cycle pulse, all pairs of a frame processed
//   busy           out  high in every state except IDLE
//   frame_cnt      out  [8]   completed-frame counter, wraps modulo 256
//   state_dbg      out  [3]   current FSM state, for observation only
//
// Handshake with each subsystem (start/done pulse protocol):
//   The scheduler raises pair_start[i] for exactly one cycle. Subsystem i then
//   owns the transaction until it raises pair_done[i] for one cycle, with
//   pair_lag slice i valid in that same cycle. The scheduler only honours
//   pair_done from the pair it is currently waiting on. A done from any other
//   pair, or a done in any other state, is dropped and has no effect. There
//   is no backpressure: a done pulse is consumed on the edge it is sampled.
// ---------------------------------------------------------------------------
module mic_pair_scheduler #(
   parameter int NUM_PAIRS   = 4,
   parameter int LAG_W       = 6,
   parameter int TIMEOUT_CYC = 1048576
) (
   input  logic                         clk_60MHz,
   input  logic                         rst_n,
   input  logic                         sched_en,
   input  logic [NUM_PAIRS-1:0]         pair_done,
   input  logic [NUM_PAIRS*LAG_W-1:0]   pair_lag,
   output logic [NUM_PAIRS-1:0]         pair_start,
   output logic [NUM_PAIRS*LAG_W-1:0]   lag_out,
   output logic [NUM_PAIRS-1:0]         timeout_flags,
   output logic                         frame_valid,
   output logic                         busy,
   output logic [7:0]                   frame_cnt,
   output logic [2:0]                   state_dbg
);

   localparam int IDX_W = $clog2(NUM_PAIRS);

   // FSM encoding
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_NEXT  = 3'd3;
   localparam logic [2:0] S_FRAME = 3'd4;

   logic [2:0]        state;
   logic [IDX_W-1:0]  idx;
   logic [7:0]        frame_cnt_q;
   logic [NUM_PAIRS*LAG_W-1:0] lag_q;

   logic              done_sel;      // done pulse from the pair being waited on
   logic [LAG_W-1:0]  lag_sel;       // that pair's lag slice
   logic              last_pair;     // idx is the final pair of the frame
   logic              frame_launch;  // a new frame begins on this edge
   logic              timeout_hit;   // watchdog expiry without a done
   logic              wait_exit;     // WAIT leaves on this edge

   assign done_sel  = pair_done[idx];
   assign lag_sel   = pair_lag[idx*LAG_W +: LAG_W];
   assign last_pair = (idx == IDX_W'(NUM_PAIRS - 1));

   // A frame launches from IDLE, or back-to-back from FRAME, whenever
   // sched_en is sampled high. Both paths clear the per-frame flags.
   assign frame_launch = sched_en && ((state == S_IDLE) || (state == S_FRAME));

   // -------------------------------------------------------------------------
   // Optional per-pair watchdog
   // -------------------------------------------------------------------------
`ifdef MIC_SCHED_TIMEOUT_EN
   // The counter is at least 21 bits wide. It stops at TIMEOUT_CYC-1, where
   // WAIT is forced to exit, so it can never wrap while waiting.
   localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 21) ? $clog2(TIMEOUT_CYC) : 21;

   logic [CNT_W-1:0]     wait_cnt;
   logic [NUM_PAIRS-1:0] timeout_q;

   // Done has priority: an expiry that coincides with a done is not a timeout.
   assign timeout_hit = (state == S_WAIT) && !done_sel &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_60MHz or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         timeout_q <= '0;
      end else begin
         if (state == S_START) begin
            wait_cnt <= '0;
         end else if ((state == S_WAIT) && !wait_exit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end

         if (frame_launch) begin
            timeout_q <= '0;
         end else if (timeout_hit) begin
            timeout_q[idx] <= 1'b1;
         end
      end
   end

   assign timeout_flags = timeout_q;
`else
   // Without the watchdog, TIMEOUT_CYC has no effect on the logic.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC > 0);

   assign timeout_hit   = 1'b0;
   assign timeout_flags = '0;
`endif

   assign wait_exit = (state == S_WAIT) && (done_sel || timeout_hit);

   // -------------------------------------------------------------------------
   // Main sequencer
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_60MHz or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         idx         <= '0;
         lag_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sched_en) begin
                  idx   <= '0;
                  state <= S_START;
               end
            end

            S_START: begin
               state <= S_WAIT;
            end

            S_WAIT: begin
               // Only this pair's slice is written, and only on its exit
               // edge, so lag_out stays stable between loads.
               if (wait_exit) begin
                  lag_q[idx*LAG_W +: LAG_W] <= done_sel ? lag_sel : '0;
                  state <= S_NEXT;
               end
            end

            S_NEXT: begin
               if (last_pair) begin
                  state <= S_FRAME;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= S_START;
               end
            end

            S_FRAME: begin
               frame_cnt_q <= frame_cnt_q + 8'd1;
               if (sched_en) begin
                  idx   <= '0;
                  state <= S_START;
               end else begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // Decoded straight from registered state, so an asynchronous reset clears
   // them immediately and they never outlive their state by a cycle.
   assign pair_start  = (state == S_START) ? (NUM_PAIRS'(1) << idx) : '0;
   assign frame_valid = (state == S_FRAME);
   assign busy        = (state != S_IDLE);
   assign lag_out     = lag_q;
   assign frame_cnt   = frame_cnt_q;
   assign state_dbg   = state;

endmodule

// File: tb/tb_mic_pair_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mic_pair_scheduler
//
// Directed-plus-random bench for mic_pair_scheduler. The bench plays the
// role of the four correlator subsystems. It answers each start pulse with a
// done pulse after a chosen delay and carries a chosen lag. The expected
// results come from a frame-level model: the order in which pairs should be
// started, the lag that should be stored for each pair, the timeout flags,
// and the completed-frame count modulo 256.
// ---------------------------------------------------------------------------
module tb_mic_pair_scheduler;

  localparam int NP = 4;
  localparam int LW = 6;
  localparam int TO = 64;

  // clock / reset
  logic clk_60MHz = 1'b0;
  logic rst_n     = 1'b0;
  always #8 clk_60MHz = ~clk_60MHz;

  logic               sched_en;
  logic [NP-1:0]      pair_done;
  logic [NP*LW-1:0]   pair_lag;
  logic [NP-1:0]      pair_start;
  logic [NP*LW-1:0]   lag_out;
  logic [NP-1:0]      timeout_flags;
  logic               frame_valid;
  logic               busy;
  logic [7:0]         frame_cnt;
  logic [2:0]         state_dbg;

  mic_pair_scheduler #(
    .NUM_PAIRS   (NP),
    .LAG_W       (LW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_60MHz     (clk_60MHz),
    .rst_n         (rst_n),
    .sched_en      (sched_en),
    .pair_done     (pair_done),
    .pair_lag      (pair_lag),
    .pair_start    (pair_start),
    .lag_out       (lag_out),
    .timeout_flags (timeout_flags),
    .frame_valid   (frame_valid),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .state_dbg     (state_dbg)
  );

  // scoreboard / reference model
  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;
  logic [NP-1:0]    exp_flags = '0;
  logic [LW-1:0]    exp_lag [NP];
  logic [NP*LW-1:0] exp_q [$];

  // per-frame scenario knobs
  logic [LW-1:0] plan_lag [NP];
  int fixed_delay  = 0;   // 0 -> random delay
  int silent_pair  = -1;  // pair that never answers
  int spur_during  = -1;  // pair during whose wait a foreign done is pulsed
  int spur_pair    = -1;  // pair whose done is pulsed spuriously
  int drop_en_pair = -1;  // sched_en drops during this pair's wait

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP*LW-1:0] pack_lags();
    logic [NP*LW-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[i*LW +: LW] = exp_lag[i];
    return v;
  endfunction

  task automatic model_reset();
    exp_cnt   = 0;
    exp_flags = '0;
    for (int i = 0; i < NP; i++) exp_lag[i] = '0;
    exp_q.delete();
  endtask

  // driver: bounded wait for the next start, then check it targets pair i
  task automatic wait_start(input int i);
    int k;
    k = 0;
    while (pair_start === '0 && k < 300) begin
      @(negedge clk_60MHz);
      k++;
    end
    check($sformatf("start_p%0d", i), 64'(pair_start), 64'(NP'(1) << i));
    check($sformatf("busy_p%0d", i), 64'(busy), 64'(1));
  endtask

  // driver: answer pair i d cycles after its start edge (called at the start negedge)
  task automatic do_done(input int i, input int d, input logic [LW-1:0] lag);
    int dd;
    dd = d;
    if (spur_pair >= 0 && spur_during == i) begin
      @(negedge clk_60MHz);
      pair_done[spur_pair] = 1'b1;
      pair_lag[spur_pair*LW +: LW] = ~exp_lag[spur_pair];
      @(negedge clk_60MHz);
      pair_done = '0;
      check("spur_ignored_lags", 64'(lag_out), 64'(pack_lags()));
      check("spur_no_start", 64'(pair_start), 64'(0));
      dd = dd - 2;
    end
    repeat (dd - 1) @(negedge clk_60MHz);
    pair_done[i] = 1'b1;
    pair_lag[i*LW +: LW] = lag;
    @(negedge clk_60MHz);
    pair_done = '0;
    pair_lag  = NP*LW'($urandom);
    exp_lag[i] = lag;
    check($sformatf("lag_p%0d", i), 64'(lag_out[i*LW +: LW]), 64'(lag));
  endtask

  task automatic run_frame();
    int d;
    int k;
    logic en_at_frame;
    for (int i = 0; i < NP; i++) begin
      wait_start(i);
      if (i == 0) begin
        exp_flags = '0;
        check("flags_cleared", 64'(timeout_flags), 64'(0));
      end
      if (drop_en_pair == i) sched_en = 1'b0;
      if (silent_pair == i) begin
        exp_flags[i] = 1'b1;
        exp_lag[i]   = '0;
        @(negedge clk_60MHz);
      end else begin
        d = (fixed_delay > 0) ? fixed_delay : $urandom_range(3, 8);
        do_done(i, d, plan_lag[i]);
      end
    end
    exp_q.push_back(pack_lags());
    k = 0;
    while (frame_valid !== 1'b1 && k < 20) begin
      @(negedge clk_60MHz);
      k++;
    end
    check("frame_valid", 64'(frame_valid), 64'(1));
    check("frame_lags", 64'(lag_out), 64'(exp_q.pop_front()));
    check("frame_flags", 64'(timeout_flags), 64'(exp_flags));
    check("frame_cnt_pre", 64'(frame_cnt), 64'(exp_cnt));
    en_at_frame = sched_en;
    exp_cnt = (exp_cnt + 1) % 256;
    @(negedge clk_60MHz);
    check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    check("frame_valid_pulse", 64'(frame_valid), 64'(0));
    if (en_at_frame) check("back_to_back", 64'(pair_start), 64'(1));
    else             check("idle_after", 64'(busy), 64'(0));
  endtask

  task automatic random_plan();
    for (int i = 0; i < NP; i++) plan_lag[i] = LW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 64'(pair_start), 64'(0));
    check({tag, "_lags"},  64'(lag_out), 64'(0));
    check({tag, "_flags"}, 64'(timeout_flags), 64'(0));
    check({tag, "_fv"},    64'(frame_valid), 64'(0));
    check({tag, "_busy"},  64'(busy), 64'(0));
    check({tag, "_cnt"},   64'(frame_cnt), 64'(0));
  endtask

  // safety net against a hung run
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sched_en  = 1'b0;
    pair_done = '0;
    pair_lag  = '0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk_60MHz);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk_60MHz);
    check("idle_busy", 64'(busy), 64'(0));

    // reference frame: 100-cycle responses, lags 3,-2,0,9
    plan_lag[0] = LW'(3);
    plan_lag[1] = LW'(-2);
    plan_lag[2] = LW'(0);
    plan_lag[3] = LW'(9);
    fixed_delay  = 100;
    drop_en_pair = 3;
    sched_en = 1'b1;
    @(negedge clk_60MHz);
    check("first_start_latency", 64'(pair_start), 64'(1));
    run_frame();
    check("ref_cnt", 64'(frame_cnt), 64'(1));
    fixed_delay = 0;

    // foreign done (pair 3) during the wait on pair 1 is ignored
    random_plan();
    spur_during = 1;
    spur_pair   = 3;
    sched_en = 1'b1;
    run_frame();
    spur_during = -1;
    spur_pair   = -1;

    // sched_en dropped during pair 1 wait: frame still completes once
    random_plan();
    drop_en_pair = 1;
    sched_en = 1'b1;
    run_frame();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_60MHz);
      check("no_extra_fv", 64'(frame_valid), 64'(0));
      check("stays_idle", 64'(busy), 64'(0));
    end

`ifdef MIC_SCHED_TIMEOUT_EN
    // pair 2 never answers: watchdog flags it and forces its lag to 0
    random_plan();
    silent_pair  = 2;
    drop_en_pair = 3;
    sched_en = 1'b1;
    run_frame();
    check("timeout_flags", 64'(timeout_flags), 64'(4'b0100));
    check("timeout_lag2", 64'(lag_out[2*LW +: LW]), 64'(0));
    silent_pair = -1;
`endif

    // random frames, back-to-back
    drop_en_pair = -1;
    sched_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      random_plan();
      run_frame();
    end

    // 256 back-to-back frames: frame_cnt wraps through 255 -> 0
    for (int f = 0; f < 256; f++) begin
      random_plan();
      if (f == 255) drop_en_pair = 3;
      run_frame();
    end
    drop_en_pair = -1;

    // reset during the wait on pair 2
    sched_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_start(i);
      do_done(i, 3, LW'($urandom_range(1, 63)));
    end
    wait_start(2);
    repeat (3) @(negedge clk_60MHz);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    sched_en = 1'b0;
    @(negedge clk_60MHz);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_60MHz);
      check("post_reset_no_fv", 64'(frame_valid), 64'(0));
    end
    random_plan();
    drop_en_pair = 3;
    sched_en = 1'b1;
    run_frame();
    check("restart_cnt", 64'(frame_cnt), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
